// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: FSM states, byte framing constants and the processor halt word.
package prog_loader_pkg;

  typedef enum logic [1:0] {StHdr, StLoad, StDone, StErr} load_state_e;

  localparam int unsigned HdrBytes  = 4;
  localparam int unsigned WordBytes = 4;
  localparam logic [31:0] HaltWord  = 32'h000f0033;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word packer; flags the completing byte combinationally and
// pulses word_vld the cycle after, with the finished word held on word.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
#(
  parameter int unsigned Bytes = WordBytes
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        last,
  output logic [31:0] word_next,
  output logic [31:0] word,
  output logic        word_vld
);

  localparam int unsigned IdxW = $clog2(Bytes);

  logic [IdxW-1:0] idx_q;
  logic [31:0]     shift_q;

  assign word_next = {byte_data, shift_q[31:8]};
  assign last      = byte_en && (idx_q == IdxW'(Bytes - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      shift_q  <= '0;
      word     <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= last;
      if (byte_en) begin
        shift_q <= word_next;
        idx_q   <= idx_q + 1'b1;
      end
      if (last) begin
        word <= word_next;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: takes a 4-byte little-endian word count then that many little-endian
// words from a byte stream, writes them to instruction memory, then enables the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_in_valid,
  input  logic [7:0]        w_in_data,
  output logic              w_in_ready,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_waddr,
  output logic [31:0]       w_wdata,
  output logic              w_cpu_ce,
  output logic              w_done,
  output logic              w_err,
  output logic [ADDR_W:0]   w_count
);

  localparam logic [ADDR_W:0] One = {{ADDR_W{1'b0}}, 1'b1};

  load_state_e       state_q, state_d;
  logic [ADDR_W:0]   len_q, cnt_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              body_q, done_q;
  logic              accept, last, word_vld;
  logic [31:0]       word_next, word;

  assign w_in_ready = !w_rst && (state_q == StHdr || state_q == StLoad);
  assign accept     = w_in_valid && w_in_ready;

  // Header and body words share one packer since both use the same 4-byte framing.
  prog_loader_byte_packer #(
    .Bytes (HdrBytes)
  ) u_packer (
    .clk       (w_clk),
    .rst       (w_rst),
    .byte_en   (accept),
    .byte_data (w_in_data),
    .last      (last),
    .word_next (word_next),
    .word      (word),
    .word_vld  (word_vld)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr: begin
        if (last) begin
          if (word_next == '0) begin
            state_d = StDone;
          end else if (word_next > 32'(MAX_WORDS)) begin
            state_d = StErr;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (last && (cnt_q == len_q - One)) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StDone;
      StErr:  state_d = StErr;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= StHdr;
      len_q   <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      body_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      body_q  <= (state_q == StLoad);
      // Registered a cycle behind the state so the final write lands before CPU start.
      done_q  <= (state_q == StDone);
      if (state_q == StHdr && last) begin
        len_q <= word_next[ADDR_W:0];
      end
      if (state_q == StLoad && last) begin
        waddr_q <= cnt_q[ADDR_W-1:0];
        cnt_q   <= cnt_q + One;
      end
    end
  end

  assign w_we     = word_vld && body_q;
  assign w_waddr  = waddr_q;
  assign w_wdata  = word;
  assign w_count  = cnt_q;
  assign w_done   = done_q;
  assign w_cpu_ce = done_q;
  assign w_err    = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized directed bench for prog_loader against a program-list reference model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned MAX_WORDS = 4096;

  logic              w_clk = 1'b0;
  logic              w_rst = 1'b1;
  logic              w_in_valid = 1'b0;
  logic [7:0]        w_in_data = 8'h00;
  logic              w_in_ready, w_we, w_cpu_ce, w_done, w_err;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata;
  logic [ADDR_W:0]   w_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int last_acc_cyc = -1;
  int done_cyc = -1;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [ADDR_W:0]   wc_q[$];
  int                wcyc_q[$];
  logic [31:0]       prog[$];

  prog_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_in_valid (w_in_valid),
    .w_in_data  (w_in_data),
    .w_in_ready (w_in_ready),
    .w_we       (w_we),
    .w_waddr    (w_waddr),
    .w_wdata    (w_wdata),
    .w_cpu_ce   (w_cpu_ce),
    .w_done     (w_done),
    .w_err      (w_err),
    .w_count    (w_count)
  );

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) cyc <= cyc + 1;

  // Observe handshakes and write pulses mid-cycle.
  always @(negedge w_clk) begin
    if (w_in_valid && w_in_ready) begin
      n_acc++;
      last_acc_cyc = cyc;
    end
    if (w_we) begin
      wa_q.push_back(w_waddr);
      wd_q.push_back(w_wdata);
      wc_q.push_back(w_count);
      wcyc_q.push_back(cyc);
    end
    if (w_done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic clear_mon();
    n_acc = 0;
    last_acc_cyc = -1;
    done_cyc = -1;
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    wcyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      w_in_valid = 1'b0;
      w_in_data  = 8'($urandom);
      tick();
    end
    w_in_valid = 1'b1;
    w_in_data  = b;
    tick();
    w_in_valid = 1'b0;
    w_in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], int'($urandom_range(gmax, gmin)));
    end
  endtask

  task automatic do_reset();
    clear_mon();
    w_rst      = 1'b1;
    w_in_valid = 1'b1;
    w_in_data  = 8'($urandom);
    #1;
    chk("rst_ready", 64'(w_in_ready), 64'(0));
    tick();
    tick();
    w_rst      = 1'b0;
    w_in_valid = 1'b0;
    #1;
    chk("rst_we", 64'(w_we), 64'(0));
    chk("rst_waddr", 64'(w_waddr), 64'(0));
    chk("rst_wdata", 64'(w_wdata), 64'(0));
    chk("rst_ce", 64'(w_cpu_ce), 64'(0));
    chk("rst_done", 64'(w_done), 64'(0));
    chk("rst_err", 64'(w_err), 64'(0));
    chk("rst_count", 64'(w_count), 64'(0));
    chk("rst_ready_after", 64'(w_in_ready), 64'(1));
    chk("rst_no_accept_or_write", 64'(n_acc + wa_q.size()), 64'(0));
    clear_mon();
  endtask

  // Send header + prog, then compare the write log against the program list.
  task automatic run_load(input int gmin, input int gmax);
    int n;
    n = prog.size();
    send_word(32'(n), gmin, gmax);
    for (int i = 0; i < n; i++) send_word(prog[i], gmin, gmax);
    chk("ready_low_after_last", 64'(w_in_ready), 64'(0));
    chk("ce_not_yet", 64'(w_cpu_ce), 64'(0));
    repeat (4) tick();
    chk("bytes_accepted", 64'(n_acc), 64'(4 + 4 * n));
    chk("write_count", 64'(wa_q.size()), 64'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk("wr_addr", 64'(wa_q[i]), 64'(i));
      chk("wr_data", 64'(wd_q[i]), 64'(prog[i]));
      chk("wr_count", 64'(wc_q[i]), 64'(i + 1));
    end
    if (n > 0 && wcyc_q.size() > 0) begin
      chk("last_wr_timing", 64'(wcyc_q[wcyc_q.size() - 1]), 64'(last_acc_cyc + 1));
    end
    chk("done_timing", 64'(done_cyc), 64'(last_acc_cyc + 2));
    chk("done_hold", 64'(w_done), 64'(1));
    chk("ce_hold", 64'(w_cpu_ce), 64'(1));
    chk("err_clear", 64'(w_err), 64'(0));
    chk("final_count", 64'(w_count), 64'(n));
    chk("ready_done", 64'(w_in_ready), 64'(0));
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
    if (n > 0) prog[n-1] = HaltWord;
  endtask

  initial begin
    int saved_count, saved_acc, saved_wr;
    tick();
    do_reset();

    // Single word, back-to-back bytes.
    prog.delete();
    prog.push_back(32'h0000_0013);
    run_load(0, 0);

    // Three words with valid toggling every other cycle.
    do_reset();
    rand_prog(3);
    run_load(1, 1);

    // Bytes offered after load complete are ignored.
    saved_count = int'(w_count);
    saved_acc   = n_acc;
    saved_wr    = wa_q.size();
    w_in_valid  = 1'b1;
    repeat (6) begin
      w_in_data = 8'($urandom);
      tick();
    end
    w_in_valid = 1'b0;
    chk("post_done_accept", 64'(n_acc), 64'(saved_acc));
    chk("post_done_write", 64'(wa_q.size()), 64'(saved_wr));
    chk("post_done_count", 64'(w_count), 64'(saved_count));
    chk("post_done_ce", 64'(w_cpu_ce), 64'(1));

    // Empty program.
    do_reset();
    prog.delete();
    run_load(0, 2);

    // Length one past the limit.
    do_reset();
    send_word(32'(MAX_WORDS + 1), 0, 0);
    chk("err_set", 64'(w_err), 64'(1));
    chk("err_ready", 64'(w_in_ready), 64'(0));
    w_in_valid = 1'b1;
    repeat (8) begin
      w_in_data = 8'($urandom);
      tick();
    end
    w_in_valid = 1'b0;
    chk("err_accepts", 64'(n_acc), 64'(4));
    chk("err_writes", 64'(wa_q.size()), 64'(0));
    chk("err_hold", 64'(w_err), 64'(1));
    chk("err_ce", 64'(w_cpu_ce), 64'(0));
    chk("err_done", 64'(w_done), 64'(0));

    // Reset in the middle of word 1, then a fresh load.
    do_reset();
    rand_prog(2);
    send_word(32'd2, 0, 1);
    send_word(prog[0], 0, 1);
    send_byte(prog[1][7:0], 0);
    send_byte(prog[1][15:8], 1);
    tick();
    tick();
    chk("partial_writes", 64'(wa_q.size()), 64'(1));
    if (wa_q.size() > 0) chk("partial_w0_data", 64'(wd_q[0]), 64'(prog[0]));
    chk("partial_count", 64'(w_count), 64'(1));
    chk("partial_ce", 64'(w_cpu_ce), 64'(0));
    do_reset();
    rand_prog(int'($urandom_range(8, 1)));
    run_load(0, 3);

    // Random programs with random idle gaps.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      rand_prog(int'($urandom_range(20, 1)));
      run_load(0, 3);
    end

    // Largest legal program.
    do_reset();
    rand_prog(MAX_WORDS);
    run_load(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
